// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, keeps one instruction-memory read outstanding, buffers words for decode.
// Build option IFU_MISALIGN_TRAP_EN: a misaligned redirect queues a NOP fault entry and halts fetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_fault
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [31:0]      NOP_INST = 32'h0000_0013;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             halt_pend_q, halt_pend_d;
  logic             active_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, wr_idx;
  logic [PTR_W:0]   count_q;
  logic [31:0]      fifo_pc   [FIFO_DEPTH];
  logic [31:0]      fifo_inst [FIFO_DEPTH];
  logic [31:0]      redir_pc, wr_pc, wr_inst;
  logic             redir_bad, push, push_fault, pop, flush, empty, full;

`ifdef IFU_MISALIGN_TRAP_EN
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redir_bad = 1'b0;
`endif
  assign redir_pc  = redirect_pc & 32'hFFFF_FFFC;

  assign empty     = (count_q == '0);
  assign full      = (count_q >= CNT_FULL);
  assign if_valid  = !empty && !redirect_valid;
  assign pop       = if_valid && if_ready;
  assign imem_addr = pc_q;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    halt_pend_d = halt_pend_q;
    flush       = 1'b0;
    push        = 1'b0;
    push_fault  = 1'b0;
    imem_req    = 1'b0;
    case (state_q)
      S_FETCH, S_HALT: begin
        if (redirect_valid) begin
          flush      = 1'b1;
          push_fault = redir_bad;
          pc_d       = redir_pc;
          state_d    = redir_bad ? S_HALT : S_FETCH;
        end else if (state_q == S_FETCH && active_q && !full) begin
          imem_req = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          flush       = 1'b1;
          push_fault  = redir_bad;
          pc_d        = redir_pc;
          halt_pend_d = redir_bad;
          if (imem_rvalid) state_d = redir_bad ? S_HALT : S_FETCH;
          else             state_d = S_DROP;
        end else if (imem_rvalid) begin
          push    = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          flush       = 1'b1;
          push_fault  = redir_bad;
          pc_d        = redir_pc;
          halt_pend_d = redir_bad;
          if (imem_rvalid) state_d = redir_bad ? S_HALT : S_FETCH;
        end else if (imem_rvalid) begin
          state_d = halt_pend_q ? S_HALT : S_FETCH;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  // active_q holds off the first request until the clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      halt_pend_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      halt_pend_q <= halt_pend_d;
      active_q    <= 1'b1;
    end
  end

  // Flush wins over push/pop; a misaligned-redirect fault entry lands in slot 0 of the emptied FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= push_fault ? PTR_ONE : '0;
      count_q  <= push_fault ? CNT_ONE : '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_q <= count_q + CNT_ONE;
      else if (pop && !push) count_q <= count_q - CNT_ONE;
    end
  end

  always_comb begin
    wr_idx  = wr_ptr_q;
    wr_pc   = pc_q;
    wr_inst = imem_rdata;
    if (push_fault) begin
      wr_idx  = '0;
      wr_pc   = redirect_pc;
      wr_inst = NOP_INST;
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  logic fifo_fault [FIFO_DEPTH];
`endif

  // NOTE: buffer storage is not reset; the count gates every read, so stale slots never reach decode.
  always_ff @(posedge clk) begin
    if (push || push_fault) begin
      fifo_pc[wr_idx]    <= wr_pc;
      fifo_inst[wr_idx]  <= wr_inst;
`ifdef IFU_MISALIGN_TRAP_EN
      fifo_fault[wr_idx] <= push_fault;
`endif
    end
  end

  assign if_inst = empty ? '0 : fifo_inst[rd_ptr_q];
  assign if_pc   = empty ? '0 : fifo_pc[rd_ptr_q];
`ifdef IFU_MISALIGN_TRAP_EN
  assign if_fault = !empty && fifo_fault[rd_ptr_q];
`else
  assign if_fault = 1'b0;
`endif

endmodule
